// File: rtl/fifo_axis_pkg.sv
// Shared definitions for the stream FIFO egress stage.
// Holds the bit layout of the 45-bit FIFO word, the egress FSM state
// encoding and the packed field struct used to unpack a word into
// AXI-Stream fields.
package fifo_axis_pkg;

  localparam int WORD_W    = 45;
  localparam int TDATA_LSB = 0;
  localparam int TDATA_W   = 32;
  localparam int TSTRB_LSB = 32;
  localparam int TSTRB_W   = 4;
  localparam int TKEEP_LSB = 36;
  localparam int TKEEP_W   = 4;
  localparam int TLAST_BIT = 40;
  localparam int TUSER_LSB = 41;
  localparam int TUSER_W   = 2;
  localparam int TID_LSB   = 43;
  localparam int TID_W     = 2;

  typedef enum logic {
    ST_PASS  = 1'b0,
    ST_FLUSH = 1'b1
  } egress_state_e;

  // Member order is MSB first, so the struct overlays the FIFO word
  // exactly: tid[44:43] tuser[42:41] tlast[40] tkeep[39:36]
  // tstrb[35:32] tdata[31:0].
  typedef struct packed {
    logic [TID_W-1:0]   tid;
    logic [TUSER_W-1:0] tuser;
    logic               tlast;
    logic [TKEEP_W-1:0] tkeep;
    logic [TSTRB_W-1:0] tstrb;
    logic [TDATA_W-1:0] tdata;
  } axis_word_t;

endpackage

// File: rtl/fifo_axis_egress_skid.sv
// axis_skid2: generic 2-entry ready/valid skid buffer.
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   push          write push_data this cycle (caller guarantees occ<2
//                 unless a pop happens in the same cycle)
//   push_data     W-bit entry to store
//   out_ready     downstream ready
//   out_valid     head entry present (occ != 0)
//   out_data      head entry; held stable until popped
//   occ           current occupancy, 0..2
// Handshake: an entry leaves when out_valid & out_ready at a rising edge;
// out_valid never depends on out_ready, and out_data only changes on a pop
// or on a push into an empty buffer.
module axis_skid2 #(
  parameter int W = 45
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = head_q;
  assign occ       = occ_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = push_data;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          tail_d = push_data;
          occ_d  = 2'd2;
        end
      end
      2'b01: begin
        // Tail slides into head; stale tail contents are harmless when
        // occ drops to 0 because out_valid is then low.
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_axis_egress.sv
// fifo_axis_egress: pops 45-bit words from the stream FIFO read port and
// presents them as an AXI-Stream master through a 2-entry skid buffer.
// Enforces a maximum packet length (truncating with a forced tlast),
// supports discarding the rest of the current packet, and counts emitted
// packets and discarded words.
// Ports:
//   axis_clk, axi_reset      clock, synchronous active-high reset
//   r_vld / r_rdy / data_out FIFO read port (accept = r_vld & r_rdy)
//   m_axis_*                 AXI-Stream master
//   flush_req                pulse: drop the remainder of the input packet
//   err_clr / err_oversize   sticky truncation flag and its clear
//   pkt_cnt                  packets emitted (wraps)
//   drop_cnt                 words discarded (saturates)
// Handshakes: a transfer occurs on a rising edge where valid & ready are
// both high; valid never waits on ready, and r_rdy has no combinational
// dependence on m_axis_tready.
module fifo_axis_egress
  import fifo_axis_pkg::*;
#(
  parameter int WIDTH     = 45,
  parameter int MAX_BEATS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             axis_clk,
  input  logic             axi_reset,
  input  logic             r_vld,
  output logic             r_rdy,
  input  logic [WIDTH-1:0] data_out,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tstrb,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic [1:0]       m_axis_tuser,
  output logic [1:0]       m_axis_tid,
  input  logic             flush_req,
  input  logic             err_clr,
  output logic             err_oversize,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(MAX_BEATS - 1);

  egress_state_e    state_q, state_d;
  logic [15:0]      beat_idx_q, beat_idx_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  axis_word_t       in_word, push_word, head_word;
  logic [WIDTH-1:0] head_bits;
  logic [1:0]       occ;
  logic             accept, in_pass, in_pkt, oversize, push, tx_hs;

  assign in_word = axis_word_t'(data_out);
  assign in_pass = (state_q == ST_PASS);
  assign in_pkt  = (beat_idx_q != 16'd0);

  // In FLUSH the input keeps draining even while the output is stalled.
  assign r_rdy  = ~axi_reset & (~in_pass | (occ < 2'd2));
  assign accept = r_vld & r_rdy;

  // The beat that would exceed MAX_BEATS becomes the packet's last beat.
  assign oversize = accept & in_pass & (beat_idx_q == LAST_IDX) & ~in_word.tlast;
  assign push     = accept & in_pass;

  always_comb begin
    push_word       = in_word;
    push_word.tlast = in_word.tlast | oversize;
  end

  axis_skid2 #(.W(WIDTH)) u_skid (
    .clk       (axis_clk),
    .rst       (axi_reset),
    .push      (push),
    .push_data (push_word),
    .out_ready (m_axis_tready),
    .out_valid (m_axis_tvalid),
    .out_data  (head_bits),
    .occ       (occ)
  );

  assign head_word    = axis_word_t'(head_bits);
  assign m_axis_tdata = head_word.tdata;
  assign m_axis_tstrb = head_word.tstrb;
  assign m_axis_tkeep = head_word.tkeep;
  assign m_axis_tlast = head_word.tlast;
  assign m_axis_tuser = head_word.tuser;
  assign m_axis_tid   = head_word.tid;
  assign tx_hs        = m_axis_tvalid & m_axis_tready;

  always_comb begin
    state_d    = state_q;
    beat_idx_d = beat_idx_q;
    err_d      = err_q;
    pkt_d      = pkt_q;
    drop_d     = drop_q;

    if (accept) begin
      beat_idx_d = (in_word.tlast | oversize) ? 16'd0 : beat_idx_q + 16'd1;
    end

    unique case (state_q)
      ST_PASS: begin
        if (oversize) begin
          state_d = ST_FLUSH;
        end else if (flush_req & in_pkt & ~(accept & in_word.tlast)) begin
          // A flush that coincides with the packet's own last beat has
          // nothing left to discard.
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (accept) begin
          if (drop_q != {CNT_W{1'b1}}) drop_d = drop_q + 1'b1;
          if (in_word.tlast) state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase

    // Set takes priority over clear.
    if (oversize)     err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;

    if (tx_hs & m_axis_tlast) pkt_d = pkt_q + 1'b1;
  end

  always_ff @(posedge axis_clk) begin
    if (axi_reset) begin
      state_q    <= ST_PASS;
      beat_idx_q <= 16'd0;
      err_q      <= 1'b0;
      pkt_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_idx_q <= beat_idx_d;
      err_q      <= err_d;
      pkt_q      <= pkt_d;
      drop_q     <= drop_d;
    end
  end

  assign err_oversize = err_q;
  assign pkt_cnt      = pkt_q;
  assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_fifo_axis_egress.sv
// Self-checking bench for fifo_axis_egress (MAX_BEATS=4).
module tb_fifo_axis_egress;

  localparam int CNT_W     = 16;
  localparam int MAX_BEATS = 4;
  localparam int W         = 45;

  logic             axis_clk;
  logic             axi_reset;
  logic             r_vld;
  logic             r_rdy;
  logic [W-1:0]     data_out;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic [31:0]      m_axis_tdata;
  logic [3:0]       m_axis_tstrb;
  logic [3:0]       m_axis_tkeep;
  logic             m_axis_tlast;
  logic [1:0]       m_axis_tuser;
  logic [1:0]       m_axis_tid;
  logic             flush_req;
  logic             err_clr;
  logic             err_oversize;
  logic [CNT_W-1:0] pkt_cnt;
  logic [CNT_W-1:0] drop_cnt;

  fifo_axis_egress #(.WIDTH(W), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .axis_clk      (axis_clk),
    .axi_reset     (axi_reset),
    .r_vld         (r_vld),
    .r_rdy         (r_rdy),
    .data_out      (data_out),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tid    (m_axis_tid),
    .flush_req     (flush_req),
    .err_clr       (err_clr),
    .err_oversize  (err_oversize),
    .pkt_cnt       (pkt_cnt),
    .drop_cnt      (drop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks;
  int           n_fail;
  int           exp_pkt;
  int           exp_drop;
  logic         prev_stall;
  logic [W-1:0] prev_word;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic tlast);
    logic [31:0] d;
    logic [3:0]  s, k;
    logic [1:0]  u, i;
    d = $urandom;
    s = 4'($urandom_range(0, 15));
    k = 4'($urandom_range(0, 15));
    u = 2'($urandom_range(0, 3));
    i = 2'($urandom_range(0, 3));
    return {i, u, tlast, k, s, d};
  endfunction

  function automatic logic [W-1:0] force_last(input logic [W-1:0] w);
    logic [W-1:0] r;
    r     = w;
    r[40] = 1'b1;
    return r;
  endfunction

  // Output monitor, sampled on the falling edge: a handshake seen here
  // completes at the following rising edge.
  task automatic monitor_step();
    logic [W-1:0] obs;
    logic [W-1:0] e;
    if (axi_reset) begin
      prev_stall = 1'b0;
    end else begin
      obs = {m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tstrb, m_axis_tdata};
      if (prev_stall && m_axis_tvalid) check_eq("stall_stable", 64'(obs), 64'(prev_word));
      if (m_axis_tvalid && m_axis_tready) begin
        check_eq("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("out_word", 64'(obs), 64'(e));
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_word  = obs;
    end
  endtask

  initial begin
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge axis_clk);
      monitor_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] w);
    int n;
    n        = 0;
    r_vld    = 1'b1;
    data_out = w;
    @(negedge axis_clk);
    while (!r_rdy && n < 50) begin
      @(negedge axis_clk);
      n++;
    end
    if (!r_rdy) check_eq("send_rdy", 64'(r_rdy), 64'd1);
    @(posedge axis_clk);
    #1;
    r_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge axis_clk);
      n++;
    end
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge axis_clk);
    #1;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    @(posedge axis_clk);
    #1;
    flush_req = 1'b0;
  endtask

  task automatic apply_reset();
    axi_reset = 1'b1;
    @(posedge axis_clk);
    #1;
    check_eq("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check_eq("rst_r_rdy", 64'(r_rdy), 64'd0);
    check_eq("rst_err", 64'(err_oversize), 64'd0);
    check_eq("rst_pkt", 64'(pkt_cnt), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    check_eq("rst_fields", 64'({m_axis_tid, m_axis_tuser, m_axis_tlast, m_axis_tkeep,
                                m_axis_tstrb, m_axis_tdata}), 64'd0);
    @(posedge axis_clk);
    #1;
    axi_reset = 1'b0;
    exp_pkt   = 0;
    exp_drop  = 0;
  endtask

  task automatic send_pkt(input int beats);
    logic [W-1:0] w;
    for (int b = 0; b < beats; b++) begin
      w = mk(b == beats - 1);
      exp_q.push_back(w);
      send(w);
    end
    exp_pkt++;
  endtask

  task automatic check_stats(input string tag);
    check_eq({tag, "_pkt"}, 64'(pkt_cnt), 64'(exp_pkt));
    check_eq({tag, "_drop"}, 64'(drop_cnt), 64'(exp_drop));
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] wv[3];
  logic [W-1:0] w;
  logic         rdy_seen[5];
  int           idx;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    exp_pkt       = 0;
    exp_drop      = 0;
    axi_reset     = 1'b1;
    r_vld         = 1'b0;
    data_out      = '0;
    m_axis_tready = 1'b0;
    flush_req     = 1'b0;
    err_clr       = 1'b0;
    @(posedge axis_clk);
    #1;
    apply_reset();

    // 1: single 3-beat packet, first-word latency of one edge.
    m_axis_tready = 1'b1;
    w = mk(1'b0);
    exp_q.push_back(w);
    send(w);
    check_eq("lat_tvalid", 64'(m_axis_tvalid), 64'd1);
    check_eq("lat_tdata", 64'(m_axis_tdata), 64'(w[31:0]));
    w = mk(1'b0);
    exp_q.push_back(w);
    send(w);
    w = mk(1'b1);
    exp_q.push_back(w);
    send(w);
    exp_pkt++;
    drain();
    check_stats("t1");

    // 2: output stalled for 5 cycles with r_vld held high.
    wv[0] = mk(1'b0);
    wv[1] = mk(1'b0);
    wv[2] = mk(1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back(wv[i]);
    m_axis_tready = 1'b0;
    r_vld         = 1'b1;
    data_out      = wv[0];
    idx           = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge axis_clk);
      rdy_seen[c] = r_rdy;
      if (r_rdy) idx++;
      @(posedge axis_clk);
      #1;
      data_out = (idx < 3) ? wv[idx] : '0;
    end
    r_vld = 1'b0;
    check_eq("stall_accepts", 64'(idx), 64'd2);
    check_eq("stall_rdy_c0", 64'(rdy_seen[0]), 64'd1);
    check_eq("stall_rdy_c1", 64'(rdy_seen[1]), 64'd1);
    check_eq("stall_rdy_c2", 64'(rdy_seen[2]), 64'd0);
    check_eq("stall_rdy_c4", 64'(rdy_seen[4]), 64'd0);
    m_axis_tready = 1'b1;
    send(wv[2]);
    exp_pkt++;
    drain();
    check_stats("t2");

    // 3: 6-beat packet against MAX_BEATS=4.
    for (int b = 0; b < 6; b++) begin
      w = mk(b == 5);
      if (b < 3) exp_q.push_back(w);
      else if (b == 3) exp_q.push_back(force_last(w));
      send(w);
    end
    exp_pkt++;
    exp_drop += 2;
    drain();
    check_eq("ovs_err", 64'(err_oversize), 64'd1);
    check_stats("t3");
    send_pkt(3);
    drain();
    check_stats("t3_next");

    // 4: flush after beat 2 of a 5-beat packet.
    for (int b = 0; b < 2; b++) begin
      w = mk(1'b0);
      exp_q.push_back(w);
      send(w);
    end
    pulse_flush();
    for (int b = 2; b < 5; b++) send(mk(b == 4));
    exp_drop += 3;
    drain();
    check_stats("t4");
    send_pkt(2);
    drain();
    check_stats("t4_next");
    pulse_flush();
    send_pkt(2);
    drain();
    check_stats("t4_idle");

    // 5: reset with two entries buffered mid-packet.
    m_axis_tready = 1'b0;
    send(mk(1'b0));
    send(mk(1'b0));
    check_eq("pre_rst_rdy", 64'(r_rdy), 64'd0);
    apply_reset();
    m_axis_tready = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    check_eq("post_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    send_pkt(3);
    drain();
    check_stats("t5");

    // 6: err_clr coinciding with an oversize, then a lone err_clr.
    for (int b = 0; b < 3; b++) begin
      w = mk(1'b0);
      exp_q.push_back(w);
      send(w);
    end
    w = mk(1'b0);
    exp_q.push_back(force_last(w));
    err_clr = 1'b1;
    send(w);
    err_clr = 1'b0;
    exp_pkt++;
    check_eq("clr_set_err", 64'(err_oversize), 64'd1);
    send(mk(1'b1));
    exp_drop++;
    drain();
    check_eq("clr_set_err2", 64'(err_oversize), 64'd1);
    check_stats("t6");
    err_clr = 1'b1;
    @(posedge axis_clk);
    #1;
    err_clr = 1'b0;
    check_eq("clr_alone_err", 64'(err_oversize), 64'd0);

    repeat (3) @(posedge axis_clk);
    check_eq("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_axis_egress.md
# fifo_axis_egress

Downstream egress stage for the 45-bit stream FIFO. It pops words with the FIFO's ready/valid read port and unpacks each word into AXI-Stream master fields. A 2-entry skid buffer decouples `m_axis_tready` from the FIFO read handshake. It also enforces a maximum packet length, supports a packet-granular flush, and exports packet and drop statistics.

## Interface
Parameters:
- `WIDTH`, 45, FIFO word width; must be 45.
- `MAX_BEATS`, 256, maximum beats per packet; range 2..65535.
- `CNT_W`, 16, width of the statistics counters.

Ports:
- `axis_clk`  in  1  single clock; every register is clocked on its rising edge.
- `axi_reset`  in  1  synchronous, active-high reset.
- `r_vld`  in  1  FIFO read data valid.
- `r_rdy`  out  1  pop request to the FIFO.
- `data_out`  in  45  FIFO word: [31:0] tdata, [35:32] tstrb, [39:36] tkeep, [40] tlast, [42:41] tuser, [44:43] tid.
- `m_axis_tvalid`  out  1  AXIS master valid.
- `m_axis_tready`  in  1  AXIS master ready.
- `m_axis_tdata`  out  32  AXIS data.
- `m_axis_tstrb`, `m_axis_tkeep`  out  4 each  byte qualifiers.
- `m_axis_tlast`  out  1  end of packet.
- `m_axis_tuser`, `m_axis_tid`  out  2 each  sideband fields.
- `flush_req`  in  1  one-cycle pulse: discard the remainder of the current input packet.
- `err_clr`  in  1  clears `err_oversize`.
- `err_oversize`  out  1  sticky flag: an oversize packet was truncated.
- `pkt_cnt`  out  CNT_W  packets emitted; wraps.
- `drop_cnt`  out  CNT_W  words discarded; saturates.

## Operation
- An input accept occurs when `r_vld & r_rdy`.
- `r_rdy` is driven from registers only: `~axi_reset & (state==FLUSH | occ<2)`. It has no combinational path from `m_axis_tready`.
- Skid buffer:
  - Two entries, occupancy `occ` in 0..2.
  - Push on an accept while in PASS; pop on `m_axis_tvalid & m_axis_tready`.
  - Push and pop in the same cycle leave `occ` unchanged.
  - `m_axis_tvalid = (occ!=0)`; the head entry drives all `m_axis_*` fields.
- Input-side tracking:
  - `beat_idx` (16 bits) counts accepted words of the current packet.
  - It resets to 0 after any accepted word with tlast=1 (original or forced).
  - `in_pkt` = (`beat_idx` != 0).
- FSM, states PASS (0) and FLUSH (1):
  - PASS→FLUSH when `flush_req & in_pkt`. A `flush_req` with `in_pkt`=0 is a no-op.
  - PASS→FLUSH on oversize: an accept with `beat_idx==MAX_BEATS-1` and tlast=0.
    - That word is pushed with tlast forced to 1.
    - `err_oversize` is set.
  - In FLUSH, every accepted word is discarded and `drop_cnt` increments (saturating at all-ones).
  - FLUSH→PASS on the accepted word whose tlast=1; that word is also dropped.
  - `flush_req` in FLUSH is ignored.
  - If `flush_req` and oversize occur in the same cycle, the oversize word is still pushed (truncated), then the FSM enters FLUSH once.
  - A `flush_req` in the same cycle as an accept with tlast=1: the word is pushed normally and the FSM stays in PASS, because the packet is complete.
  - Entries already in the skid buffer are always emitted; flush never discards them.
- Statistics:
  - `pkt_cnt` increments on each output handshake with `m_axis_tlast=1`; it wraps modulo 2^CNT_W.
  - `err_oversize` is cleared by `err_clr`. If set and clear coincide, set wins.

## Timing
- Reset (`axi_reset`=1 at a clock edge) gives:
  - state=PASS, `occ`=0, `beat_idx`=0.
  - `m_axis_tvalid`=0, `r_rdy`=0, `err_oversize`=0, `pkt_cnt`=0, `drop_cnt`=0.
  - Skid data registers = 0, so all `m_axis_*` fields read 0.
- Reset asserted mid-packet abandons all buffered entries and counters; nothing is emitted afterwards.
- A word accepted at edge N is visible on `m_axis_*` after edge N (latency 1), provided `occ` was 0.
- With `m_axis_tready` held high, throughput is 1 word/cycle and `occ` stays at 1.
- With `m_axis_tready` low, `occ` reaches 2 and `r_rdy` drops the cycle after the second accept.
- `m_axis_*` are stable while `m_axis_tvalid & ~m_axis_tready`.
- In FLUSH, `r_rdy`=1 regardless of `occ`, so discarding continues while the output is stalled.

## Structure
- Package `fifo_axis_pkg` holds:
  - Field offset/width localparams (`TDATA_LSB`=0 … `TID_LSB`=43).
  - The state encoding (PASS/FLUSH).
  - The `axis_word_t` field typedef.
- Sub-module `axis_skid2`: a generic 2-entry ready/valid skid buffer, parameterised on width. It owns `occ`, push/pop and head selection.
- The top level contains the FSM, beat tracking, tlast forcing and statistics.

## Test plan
- Single 3-beat packet, `m_axis_tready`=1: words emitted in order, each 1 cycle after its accept; `pkt_cnt`=1; `drop_cnt`=0.
- Hold `m_axis_tready`=0 for 5 cycles with `r_vld`=1: exactly 2 accepts, `r_rdy`=0 from the 3rd cycle, output word stable; after release, order is preserved.
- `MAX_BEATS`=4, 6-beat packet: 4 words emitted with tlast on beat 4; `err_oversize`=1; beats 5–6 dropped; `drop_cnt`=2; `pkt_cnt`=1; the next packet passes intact.
- `flush_req` after beat 2 of a 5-beat packet: beats 1–2 emitted without tlast, beats 3–5 dropped, `drop_cnt`=3, FSM back in PASS. `flush_req` between packets changes nothing.
- Reset asserted with `occ`=2 mid-packet: next cycle `m_axis_tvalid`=0, `r_rdy`=0, all counters 0; the next packet is emitted correctly.
- `err_clr` and a new oversize in the same cycle: `err_oversize` stays 1. A later lone `err_clr` clears it to 0.
